// File: rtl/vec_alu_seq_if.sv
// Command handshake bundle for vec_alu_seq: valid/ready plus the latched command fields.
interface vec_alu_seq_if #(
  parameter int op_width_p = 2,
  parameter int els_p      = 8,
  parameter int regs_p     = 8
);
  localparam int rw = $clog2(regs_p);
  localparam int ew = $clog2(els_p);

  logic                  v_i;
  logic                  ready_o;
  logic [op_width_p-1:0] op_i;
  logic [rw-1:0]         vs1_i;
  logic [rw-1:0]         vs2_i;
  logic [rw-1:0]         vd_i;
  logic [ew-1:0]         len_i;

  modport master (output v_i, op_i, vs1_i, vs2_i, vd_i, len_i, input ready_o);
  modport slave  (input v_i, op_i, vs1_i, vs2_i, vd_i, len_i, output ready_o);
endinterface

// File: rtl/vec_alu_seq.sv
// Sequencer for element-wise vector ALU ops: read (p0) -> ALU (p1) -> writeback (p2).
// Optional flag accumulation is built only when VEC_ALU_SEQ_FLAGS_EN is defined.
module vec_alu_seq #(
  parameter int vdw_p      = 32,
  parameter int op_width_p = 2,
  parameter int els_p      = 8,
  parameter int regs_p     = 8,
  localparam int rw = $clog2(regs_p),
  localparam int ew = $clog2(els_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  vec_alu_seq_if.slave          cmd,
  output logic                  rd_v_o,
  output logic [rw-1:0]         rd_reg1_o,
  output logic [rw-1:0]         rd_reg2_o,
  output logic [ew-1:0]         rd_el_o,
  input  logic [vdw_p-1:0]      rd_a_i,
  input  logic [vdw_p-1:0]      rd_b_i,
  output logic [vdw_p-1:0]      alu_a_o,
  output logic [vdw_p-1:0]      alu_b_o,
  output logic [op_width_p-1:0] alu_op_o,
  input  logic [vdw_p-1:0]      alu_result_i,
  input  logic                  alu_overflow_i,
  input  logic                  alu_zero_i,
  input  logic                  alu_negative_i,
  output logic                  wr_v_o,
  output logic [rw-1:0]         wr_reg_o,
  output logic [ew-1:0]         wr_el_o,
  output logic [vdw_p-1:0]      wr_data_o,
  output logic                  done_o,
  output logic                  illegal_o,
  output logic                  any_ovf_o,
  output logic                  all_zero_o,
  output logic                  any_neg_o
);

  localparam logic [op_width_p-1:0] OP_ILLEGAL = op_width_p'(3);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  accept;
  logic [op_width_p-1:0] op_q;
  logic                  illegal_q;
  logic [rw-1:0]         vs1_q, vs2_q, vd_q;
  logic [ew-1:0]         last_q;
  logic [ew-1:0]         el_q;
  logic                  vld_p0, vld_p1, vld_p2;
  logic [ew-1:0]         el_p1, el_p2;
  logic [vdw_p-1:0]      data_p2;
  logic                  last_wr;

  assign accept  = cmd.v_i && (state_q == IDLE);
  assign last_wr = vld_p2 && (el_p2 == last_q);

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    vld_p0  = 1'b0;
    case (state_q)
      IDLE:  if (cmd.v_i) state_d = (cmd.op_i == OP_ILLEGAL) ? DONE : READ;
      READ: begin
        vld_p0 = 1'b1;
        if (el_q == last_q) state_d = DRAIN;
      end
      DRAIN: if (last_wr) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      el_q      <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (accept) begin
        el_q      <= '0;
        op_q      <= cmd.op_i;
        illegal_q <= (cmd.op_i == OP_ILLEGAL);
      end else if (vld_p0 && (el_q != last_q)) begin
        el_q <= el_q + 1'b1;
      end
    end
  end

  // len 0 wraps to all-ones, i.e. last index els_p-1
  always_ff @(posedge clk_i) begin
    if (accept) begin
      vs1_q  <= cmd.vs1_i;
      vs2_q  <= cmd.vs2_i;
      vd_q   <= cmd.vd_i;
      last_q <= cmd.len_i - 1'b1;
    end
    el_p1   <= el_q;
    el_p2   <= el_p1;
    data_p2 <= alu_result_i;
  end

  assign cmd.ready_o = (state_q == IDLE);

  // p0: read request
  assign rd_v_o    = vld_p0;
  assign rd_reg1_o = vld_p0 ? vs1_q : '0;
  assign rd_reg2_o = vld_p0 ? vs2_q : '0;
  assign rd_el_o   = vld_p0 ? el_q  : '0;

  // p1: returned data feeds the ALU
  assign alu_a_o  = vld_p1 ? rd_a_i : '0;
  assign alu_b_o  = vld_p1 ? rd_b_i : '0;
  assign alu_op_o = op_q;

  // p2: registered writeback
  assign wr_v_o    = vld_p2;
  assign wr_reg_o  = vld_p2 ? vd_q    : '0;
  assign wr_el_o   = vld_p2 ? el_p2   : '0;
  assign wr_data_o = vld_p2 ? data_p2 : '0;

  assign done_o    = (state_q == DONE);
  assign illegal_o = done_o && illegal_q;

`ifdef VEC_ALU_SEQ_FLAGS_EN
  logic any_ovf_q, all_zero_q, any_neg_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      any_ovf_q  <= 1'b0;
      all_zero_q <= 1'b0;
      any_neg_q  <= 1'b0;
    end else if (accept) begin
      any_ovf_q  <= 1'b0;
      all_zero_q <= 1'b1;
      any_neg_q  <= 1'b0;
    end else if (vld_p1) begin
      any_ovf_q  <= any_ovf_q  | alu_overflow_i;
      all_zero_q <= all_zero_q & alu_zero_i;
      any_neg_q  <= any_neg_q  | alu_negative_i;
    end
  end

  assign any_ovf_o  = any_ovf_q;
  assign all_zero_o = all_zero_q;
  assign any_neg_o  = any_neg_q;
`else
  logic flags_unused;
  assign flags_unused = alu_overflow_i ^ alu_zero_i ^ alu_negative_i;

  assign any_ovf_o  = 1'b0;
  assign all_zero_o = 1'b0;
  assign any_neg_o  = 1'b0;
`endif

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: directed table, back-to-back, mid-command reset, random commands.
module tb_vec_alu_seq;
  localparam int VDW  = 32;
  localparam int OPW  = 2;
  localparam int ELS  = 8;
  localparam int REGS = 8;
  localparam int RW   = 3;
  localparam int EW   = 3;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  vec_alu_seq_if #(.op_width_p(OPW), .els_p(ELS), .regs_p(REGS)) cmd_if();

  logic           rd_v_o;
  logic [RW-1:0]  rd_reg1_o, rd_reg2_o;
  logic [EW-1:0]  rd_el_o;
  logic [VDW-1:0] rd_a_i, rd_b_i;
  logic [VDW-1:0] alu_a_o, alu_b_o;
  logic [OPW-1:0] alu_op_o;
  logic [VDW-1:0] alu_result_i;
  logic           alu_overflow_i, alu_zero_i, alu_negative_i;
  logic           wr_v_o;
  logic [RW-1:0]  wr_reg_o;
  logic [EW-1:0]  wr_el_o;
  logic [VDW-1:0] wr_data_o;
  logic           done_o, illegal_o, any_ovf_o, all_zero_o, any_neg_o;

  vec_alu_seq #(.vdw_p(VDW), .op_width_p(OPW), .els_p(ELS), .regs_p(REGS)) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd(cmd_if),
    .rd_v_o(rd_v_o), .rd_reg1_o(rd_reg1_o), .rd_reg2_o(rd_reg2_o), .rd_el_o(rd_el_o),
    .rd_a_i(rd_a_i), .rd_b_i(rd_b_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_overflow_i(alu_overflow_i),
    .alu_zero_i(alu_zero_i), .alu_negative_i(alu_negative_i),
    .wr_v_o(wr_v_o), .wr_reg_o(wr_reg_o), .wr_el_o(wr_el_o), .wr_data_o(wr_data_o),
    .done_o(done_o), .illegal_o(illegal_o),
    .any_ovf_o(any_ovf_o), .all_zero_o(all_zero_o), .any_neg_o(any_neg_o)
  );

  // Reference ALU: {overflow, zero, negative, result}
  function automatic logic [VDW+2:0] alu_f(input logic [OPW-1:0] op, input logic [VDW-1:0] a, input logic [VDW-1:0] b);
    logic [2*VDW-1:0] w;
    logic [VDW-1:0]   r;
    logic             ov;
    w = '0;
    case (op)
      2'd0: begin w = (2*VDW)'(a) + (2*VDW)'(b); r = w[VDW-1:0]; ov = |w[2*VDW-1:VDW]; end
      2'd1: begin r = a - b; ov = (a < b); end
      2'd2: begin w = (2*VDW)'(a) * (2*VDW)'(b); r = w[VDW-1:0]; ov = |w[2*VDW-1:VDW]; end
      default: begin r = '0; ov = 1'b0; end
    endcase
    return {ov, (r == '0), r[VDW-1], r};
  endfunction

  logic [VDW+2:0] alu_pack;
  always_comb alu_pack = alu_f(alu_op_o, alu_a_o, alu_b_o);
  assign alu_result_i   = alu_pack[VDW-1:0];
  assign alu_negative_i = alu_pack[VDW];
  assign alu_zero_i     = alu_pack[VDW+1];
  assign alu_overflow_i = alu_pack[VDW+2];

  // Register file with one-cycle read latency
  logic [VDW-1:0] mem [REGS][ELS];
  always @(posedge clk) begin
    if (rd_v_o) begin
      rd_a_i <= mem[rd_reg1_o][rd_el_o];
      rd_b_i <= mem[rd_reg2_o][rd_el_o];
    end
    if (wr_v_o) mem[wr_reg_o][wr_el_o] <= wr_data_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int exp_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_flags(input string tag, input bit ovf, input bit zero, input bit neg);
`ifdef VEC_ALU_SEQ_FLAGS_EN
    chk({tag, "_any_ovf"}, 64'(any_ovf_o), 64'(ovf));
    chk({tag, "_all_zero"}, 64'(all_zero_o), 64'(zero));
    chk({tag, "_any_neg"}, 64'(any_neg_o), 64'(neg));
`else
    chk({tag, "_flags_tied"}, 64'({any_ovf_o, all_zero_o, any_neg_o}), 64'(0));
`endif
  endtask

  task automatic fill(input int r, input logic [VDW-1:0] v);
    for (int e = 0; e < ELS; e++) mem[r][e] = v;
  endtask

  // Issue one command, check every cycle against the model until done.
  task automatic do_cmd(input logic [OPW-1:0] op, input logic [RW-1:0] vs1, input logic [RW-1:0] vs2,
                        input logic [RW-1:0] vd, input logic [EW-1:0] len, input bit keep_v, input bit check_lat);
    int T, N;
    bit acc;
    logic [VDW-1:0] exp_d [ELS];
    logic [VDW+2:0] r;
    bit e_ovf, e_zero, e_neg;
    cmd_if.op_i = op; cmd_if.vs1_i = vs1; cmd_if.vs2_i = vs2; cmd_if.vd_i = vd; cmd_if.len_i = len;
    cmd_if.v_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (cmd_if.ready_o) acc = 1'b1;
    end
    if (!acc) begin
      chk("accept_timeout", 64'(0), 64'(1));
      cmd_if.v_i = 1'b0;
      return;
    end
    T = cyc;
    if (check_lat) chk("accept_cycle", 64'(T), 64'(exp_acc));
    N = (len == 0) ? ELS : int'(len);
    e_ovf = 1'b0; e_zero = 1'b1; e_neg = 1'b0;
    if (op != 2'd3) begin
      for (int e = 0; e < N; e++) begin
        r = alu_f(op, mem[vs1][e], mem[vs2][e]);
        exp_d[e] = r[VDW-1:0];
        e_ovf  = e_ovf  | r[VDW+2];
        e_zero = e_zero & r[VDW+1];
        e_neg  = e_neg  | r[VDW];
      end
    end
    @(posedge clk); #1;
    if (!keep_v) cmd_if.v_i = 1'b0;
    if (op == 2'd3) begin
      @(negedge clk);
      chk("ill_done", 64'(done_o), 64'(1));
      chk("ill_illegal", 64'(illegal_o), 64'(1));
      chk("ill_no_rd", 64'(rd_v_o), 64'(0));
      chk("ill_no_wr", 64'(wr_v_o), 64'(0));
      chk_flags("ill", 1'b0, 1'b1, 1'b0);
      exp_acc = T + 2;
      return;
    end
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      chk("ready_busy", 64'(cmd_if.ready_o), 64'(0));
      chk("rd_v", 64'(rd_v_o), 64'(k <= N));
      if (k <= N) begin
        chk("rd_el", 64'(rd_el_o), 64'(k - 1));
        chk("rd_reg1", 64'(rd_reg1_o), 64'(vs1));
        chk("rd_reg2", 64'(rd_reg2_o), 64'(vs2));
      end
      if (k >= 2 && k <= N + 1) chk("alu_op", 64'(alu_op_o), 64'(op));
      chk("wr_v", 64'(wr_v_o), 64'(k >= 3 && k <= N + 2));
      if (k >= 3 && k <= N + 2) begin
        chk("wr_reg", 64'(wr_reg_o), 64'(vd));
        chk("wr_el", 64'(wr_el_o), 64'(k - 3));
        chk("wr_data", 64'(wr_data_o), 64'(exp_d[k-3]));
      end
      chk("done", 64'(done_o), 64'(k == N + 3));
      if (k == N + 3) begin
        chk("done_illegal", 64'(illegal_o), 64'(0));
        chk_flags("done", e_ovf, e_zero, e_neg);
      end
      // A request while busy must be ignored entirely
      if (!keep_v && N >= 2 && k == 2) begin
        cmd_if.v_i = 1'b1; cmd_if.op_i = 2'd3; cmd_if.vd_i = vd ^ 3'd1; cmd_if.len_i = 3'd1;
      end
      if (!keep_v && N >= 2 && k == 3) cmd_if.v_i = 1'b0;
    end
    exp_acc = T + N + 4;
  endtask

  typedef struct {
    logic [OPW-1:0] op;
    logic [RW-1:0]  vs1, vs2, vd;
    logic [EW-1:0]  len;
    logic [VDW-1:0] a, b, exp;
    bit             ovf, zero, neg;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int T;
    bit acc;
    reset_i = 1'b0;
    cmd_if.v_i = 1'b0; cmd_if.op_i = '0; cmd_if.vs1_i = '0; cmd_if.vs2_i = '0;
    cmd_if.vd_i = '0; cmd_if.len_i = '0;
    for (int r = 0; r < REGS; r++) fill(r, '0);

    tbl[0] = '{op:2'd0, vs1:3'd1, vs2:3'd2, vd:3'd3, len:3'd0, a:32'd1, b:32'd2, exp:32'd3, ovf:1'b0, zero:1'b0, neg:1'b0};
    tbl[1] = '{op:2'd1, vs1:3'd1, vs2:3'd2, vd:3'd3, len:3'd2, a:32'd5, b:32'd5, exp:32'd0, ovf:1'b0, zero:1'b1, neg:1'b0};
    tbl[2] = '{op:2'd2, vs1:3'd1, vs2:3'd2, vd:3'd3, len:3'd1, a:32'h10000, b:32'h10000, exp:32'd0, ovf:1'b1, zero:1'b1, neg:1'b0};
    tbl[3] = '{op:2'd3, vs1:3'd1, vs2:3'd2, vd:3'd3, len:3'd0, a:32'd1, b:32'd2, exp:32'd0, ovf:1'b0, zero:1'b1, neg:1'b0};
    tbl[4] = '{op:2'd0, vs1:3'd4, vs2:3'd5, vd:3'd6, len:3'd4, a:32'hFFFFFFFF, b:32'd1, exp:32'd0, ovf:1'b1, zero:1'b1, neg:1'b0};
    tbl[5] = '{op:2'd1, vs1:3'd4, vs2:3'd5, vd:3'd4, len:3'd3, a:32'd3, b:32'd5, exp:32'hFFFFFFFE, ovf:1'b1, zero:1'b0, neg:1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_if.ready_o), 64'(1));
    chk("rst_outs", 64'({rd_v_o, wr_v_o, done_o, illegal_o, any_ovf_o, all_zero_o, any_neg_o}), 64'(0));
    chk("rst_data", 64'({alu_a_o, wr_data_o}), 64'(0));
    chk("rst_idx", 64'({rd_reg1_o, rd_el_o, wr_reg_o, wr_el_o, alu_op_o}), 64'(0));
    @(posedge clk); #1;
    reset_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].vs1, tbl[i].a);
      fill(tbl[i].vs2, tbl[i].b);
      do_cmd(tbl[i].op, tbl[i].vs1, tbl[i].vs2, tbl[i].vd, tbl[i].len, 1'b0, i != 0);
      if (tbl[i].op != 2'd3) chk("tbl_result", 64'(mem[tbl[i].vd][0]), 64'(tbl[i].exp));
      chk_flags("tbl", tbl[i].ovf, tbl[i].zero, tbl[i].neg);
    end

    // Back-to-back in-place commands with v_i held high
    for (int e = 0; e < ELS; e++) begin mem[4][e] = 32'(10 * e); mem[5][e] = 32'(e + 1); end
    do_cmd(2'd0, 3'd4, 3'd5, 3'd4, 3'd3, 1'b1, 1'b1);
    do_cmd(2'd0, 3'd4, 3'd5, 3'd4, 3'd3, 1'b0, 1'b1);
    for (int e = 0; e < 3; e++) chk("b2b_inplace", 64'(mem[4][e]), 64'(10 * e + 2 * (e + 1)));
    chk("b2b_untouched", 64'(mem[4][3]), 64'(30));

    // Reset in cycle T+4 of an 8-element add
    fill(1, 32'd1); fill(2, 32'd2); fill(3, 32'hAAAA_AAAA);
    cmd_if.op_i = 2'd0; cmd_if.vs1_i = 3'd1; cmd_if.vs2_i = 3'd2; cmd_if.vd_i = 3'd3; cmd_if.len_i = 3'd0;
    cmd_if.v_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (cmd_if.ready_o) acc = 1'b1;
    end
    chk("rstcmd_accept", 64'(acc), 64'(1));
    T = cyc;
    @(posedge clk); #1;
    cmd_if.v_i = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rstcmd_last_wr", 64'({wr_v_o, wr_el_o}), 64'({1'b1, 3'd1}));
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(negedge clk);
    chk("abort_cycle", 64'(cyc), 64'(T + 5));
    chk("abort_ready", 64'(cmd_if.ready_o), 64'(1));
    chk("abort_outs", 64'({rd_v_o, wr_v_o, done_o, illegal_o, any_ovf_o, all_zero_o, any_neg_o, alu_op_o}), 64'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_quiet", 64'({wr_v_o, done_o}), 64'(0));
    end
    chk("abort_el0", 64'(mem[3][0]), 64'(3));
    chk("abort_el1", 64'(mem[3][1]), 64'(3));
    for (int e = 2; e < ELS; e++) chk("abort_kept", 64'(mem[3][e]), 64'(32'hAAAA_AAAA));

    // Recovery after reset, then randomized commands
    do_cmd(2'd0, 3'd1, 3'd2, 3'd0, 3'd2, 1'b0, 1'b0);
    for (int r = 0; r < REGS; r++)
      for (int e = 0; e < ELS; e++) mem[r][e] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    for (int i = 0; i < 30; i++) begin
      logic [OPW-1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_cmd(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), (i != 29) && ($urandom_range(0, 2) == 0), 1'b1);
    end
    cmd_if.v_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
